sr_drive_ctrl: RTL and testbench

SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

---
 rtl/sr_pkg.sv | 30 +++
 rtl/sr_req_fifo.sv | 53 +++++
 rtl/sr_drive_ctrl.sv | 106 ++++++++++
 tb/tb_sr_drive_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the SR flip-flop drive controller: op codes, FSM states
// and the rule mapping an op to the q value expected after the drive.
package sr_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_RESET  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_e;

  localparam int OP_W = 2;

  function automatic logic expected_of(op_e op, logic q);
    case (op)
      OP_SET:    return 1'b1;
      OP_RESET:  return 1'b0;
      OP_TOGGLE: return ~q;
      default:   return q;
    endcase
  endfunction

endpackage

// File: rtl/sr_req_fifo.sv
// Synchronous request queue; pushes while full are ignored, push+pop in one cycle
// keeps the occupancy unchanged.
module sr_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rptr_q];
  assign level   = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sr_drive_ctrl.sv
// Queued command driver for a downstream SR master-slave flip-flop: pulses s/r,
// waits for the flop to settle, then checks the fed-back q against the target.
module sr_drive_ctrl
  import sr_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PULSE_CYC  = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  input  logic [1:0]                    req_op,
  output logic                          req_ready,
  output logic                          s,
  output logic                          r,
  input  logic                          q_in,
  output logic                          done,
  output logic                          err,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int CMAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  logic            fifo_full, fifo_empty, pop;
  logic [OP_W-1:0] fifo_dout;

  state_e          state_q;
  op_e             op_q;
  logic            exp_q;
  logic [CW-1:0]   cnt_q;
  logic            s_q, r_q, done_q, err_q;

  assign pop       = (state_q == IDLE) && !fifo_empty;
  assign req_ready = !fifo_full;
  assign busy      = (state_q != IDLE);
  assign s         = s_q;
  assign r         = r_q;
  assign done      = done_q;
  assign err       = err_q;

  sr_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(OP_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .din   (req_op),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // s/r are only ever driven as complements of exp_q, so they can never overlap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= OP_HOLD;
      exp_q   <= 1'b0;
      cnt_q   <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            op_q    <= op_e'(fifo_dout);
            exp_q   <= expected_of(op_e'(fifo_dout), q_in);
            cnt_q   <= CW'(PULSE_CYC);
            state_q <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt_q != '0 && op_q != OP_HOLD) begin
            s_q   <= exp_q;
            r_q   <= ~exp_q;
            cnt_q <= cnt_q - CW'(1);
          end else begin
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            cnt_q   <= CW'(SETTLE_CYC - 1);
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            done_q  <= 1'b1;
            err_q   <= (q_in != exp_q);
            state_q <= CHECK;
          end
        end
        CHECK:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Bench for sr_drive_ctrl: a timeline model of each command checked every cycle,
// directed scenarios with literal expectations, then a randomized run with resets.
module tb_sr_drive_ctrl;
  import sr_pkg::*;

  localparam int DEPTH  = 4;
  localparam int PULSE  = 1;
  localparam int SETTLE = 2;

  logic       clk, rst, req_valid, req_ready, s, r, q_in, done, err, busy;
  logic [1:0] req_op;
  logic [$clog2(DEPTH):0] level;

  int  total = 0, bad = 0;
  int  qmode;
  logic q_ff = 1'b0, q_rand;

  sr_drive_ctrl #(.FIFO_DEPTH(DEPTH), .PULSE_CYC(PULSE), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
    .s(s), .r(r), .q_in(q_in), .done(done), .err(err), .busy(busy), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream SR flop (qmode 0), stuck-at-0 (1) or random noise (2).
  always @(posedge clk) begin
    if (s) q_ff <= 1'b1;
    else if (r) q_ff <= 1'b0;
  end
  assign q_in = (qmode == 0) ? q_ff : (qmode == 1) ? 1'b0 : q_rand;

  task automatic chk(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask

  // Model: each popped command owns a window of edges; outputs are derived from
  // the edge index relative to its pop edge.
  op_e mq[$];
  bit  act, aexp, pulse;
  op_e aop;
  int  pop_at, chk_at, idle_from, cyc, lb;
  int  accepted = 0, flushed = 0, dut_dones = 0;
  bit  e_s, e_r, e_done, e_err, e_busy;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      flushed += mq.size() + int'(act);
      mq.delete();
      act = 0; idle_from = 0;
      e_s = 0; e_r = 0; e_done = 0; e_err = 0; e_busy = 0;
    end else begin
      cyc++;
      lb = mq.size();
      if (act && cyc > chk_at) act = 0;
      if (!act && cyc >= idle_from && lb > 0) begin
        aop = mq.pop_front();
        case (aop)
          OP_SET:    aexp = 1'b1;
          OP_RESET:  aexp = 1'b0;
          OP_TOGGLE: aexp = !q_in;
          default:   aexp = q_in;
        endcase
        pop_at    = cyc;
        chk_at    = cyc + 1 + ((aop == OP_HOLD) ? 0 : PULSE) + SETTLE;
        idle_from = chk_at + 2;
        act       = 1;
      end
      if (req_valid && lb != DEPTH) begin
        mq.push_back(op_e'(req_op));
        accepted++;
      end
      pulse  = act && aop != OP_HOLD && cyc > pop_at && cyc <= pop_at + PULSE;
      e_s    = pulse && aexp;
      e_r    = pulse && !aexp;
      e_busy = act;
      e_done = act && cyc == chk_at;
      e_err  = e_done && (q_in != aexp);
    end
  end

  always @(negedge clk) begin
    chk("s", s, e_s);
    chk("r", r, e_r);
    chk("done", done, e_done);
    chk("err", err, e_err);
    chk("busy", busy, e_busy);
    chk("level", level, mq.size());
    chk("req_ready", req_ready, int'(mq.size() != DEPTH));
    total++;
    assert (!(s && r)) else begin
      bad++;
      $display("FAIL s_r_overlap: s=%0b r=%0b at %0t", s, r, $time);
    end
    if (done) dut_dones++;
  end

  task automatic issue(input op_e op);
    req_valid = 1'b1; req_op = op;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic collect(input int n, output int cnt, output logic [7:0] bits,
                         output logic saw_s, output logic saw_r, output logic last_err);
    logic lastp;
    cnt = 0; bits = '0; saw_s = 0; saw_r = 0; last_err = 0; lastp = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (s) begin saw_s = 1; lastp = 1; end
      if (r) begin saw_r = 1; lastp = 0; end
      if (done) begin cnt++; bits = {bits[6:0], lastp}; last_err = err; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int         cnt;
  logic [7:0] bits;
  logic       ss, sr, le;
  op_e        ops5 [5];

  initial begin
    req_valid = 0; req_op = 2'b00; qmode = 0; q_rand = 0;
    rst = 1'b1; #1 rst = 1'b0; #3;
    chk("rst_s", s, 0); chk("rst_r", r, 0); chk("rst_done", done, 0);
    chk("rst_err", err, 0); chk("rst_busy", busy, 0); chk("rst_level", level, 0);
    chk("rst_ready", req_ready, 1);
    repeat (2) @(negedge clk);

    // SET offered across reset release; flop follows s.
    req_valid = 1'b1; req_op = OP_SET;
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);                          // edge N accepted
    req_valid = 1'b0;
    chk("h32_level_n", level, 1); chk("h32_s_n", s, 0);
    @(negedge clk); chk("h32_s_n1", s, 0); chk("h32_busy_n1", busy, 1);
    @(negedge clk); chk("h32_s_n2", s, 1); chk("h32_r_n2", r, 0);
    @(negedge clk); chk("h32_s_n3", s, 0);
    @(negedge clk); chk("h32_done_n4", done, 0);
    @(negedge clk); chk("h32_done_n5", done, 1); chk("h32_err_n5", err, 0);
    @(negedge clk); chk("h32_done_n6", done, 0); chk("h32_busy_n6", busy, 0);

    // q stuck at 0.
    qmode = 1;
    issue(OP_SET);   collect(12, cnt, bits, ss, sr, le);
    chk("h33_set_cnt", cnt, 1); chk("h33_set_err", le, 1);
    issue(OP_RESET); collect(12, cnt, bits, ss, sr, le);
    chk("h33_rst_cnt", cnt, 1); chk("h33_rst_err", le, 0);
    qmode = 0;

    // Toggle from q=1, then hold.
    issue(OP_SET);    collect(12, cnt, bits, ss, sr, le);
    chk("h34_pre_err", le, 0);
    issue(OP_TOGGLE); collect(12, cnt, bits, ss, sr, le);
    chk("h34_tg_s", ss, 0); chk("h34_tg_r", sr, 1); chk("h34_tg_cnt", cnt, 1); chk("h34_tg_err", le, 0);
    issue(OP_HOLD);   collect(12, cnt, bits, ss, sr, le);
    chk("h34_hd_s", ss, 0); chk("h34_hd_r", sr, 0); chk("h34_hd_cnt", cnt, 1); chk("h34_hd_err", le, 0);

    // Fill the queue behind a busy command; fifth push dropped.
    ops5 = '{OP_RESET, OP_SET, OP_RESET, OP_TOGGLE, OP_SET};
    issue(OP_SET);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_op = ops5[i];
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("h35_level", level, 4); chk("h35_ready", req_ready, 0);
    collect(60, cnt, bits, ss, sr, le);
    chk("h35_dones", cnt, 4); chk("h35_order", bits, 8'h05);

    // Reset in the middle of a SET pulse with one more command queued.
    req_valid = 1'b1; req_op = OP_SET;
    @(negedge clk);
    req_op = OP_RESET;
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("h36_s_pre", s, 1); chk("h36_level_pre", level, 1);
    #1 rst = 1'b0; #1;
    chk("h36_s", s, 0); chk("h36_r", r, 0); chk("h36_level", level, 0);
    chk("h36_busy", busy, 0); chk("h36_done", done, 0); chk("h36_ready", req_ready, 1);
    @(negedge clk); @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    collect(10, cnt, bits, ss, sr, le);
    chk("h36_no_done", cnt, 0);
    issue(OP_RESET); collect(12, cnt, bits, ss, sr, le);
    chk("h36_rst_cnt", cnt, 1); chk("h36_rst_err", le, 0); chk("h36_rst_r", sr, 1);

    // Random traffic with occasional resets.
    qmode = 2;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 500) qmode = 0;
      req_valid = ($urandom_range(0, 2) != 0);
      req_op    = 2'($urandom);
      q_rand    = 1'($urandom);
      if (i == 300 || $urandom_range(0, 199) == 0) begin
        @(posedge clk); #2 rst = 1'b0; #1;
        chk("rnd_rst_s", s, 0); chk("rnd_rst_r", r, 0); chk("rnd_rst_level", level, 0);
        chk("rnd_rst_done", done, 0); chk("rnd_rst_busy", busy, 0);
        @(negedge clk); @(posedge clk); #2 rst = 1'b1;
      end
    end
    @(negedge clk);
    req_valid = 1'b0; qmode = 0;
    repeat (40) @(negedge clk);
    chk("done_vs_accepted", dut_dones, accepted - flushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
